// File: rtl/mips_hazard_scoreboard_if.sv
// Decode-stage issue fields into the hazard scoreboard and the stall/flush
// controls and pending-register view coming back out.
interface mips_hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int REG_AW = 5,
  parameter int LAT_W  = 4
);
  logic              IssueValidD;
  logic              IssueWrD;
  logic [REG_AW-1:0] IssueDstD;
  logic [LAT_W-1:0]  IssueLatD;
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic              UseRsD;
  logic              UseRtD;
  logic              BranchD;
  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic [NREGS-1:0]  PendingMask;
  logic              IssueAccepted;

  modport master (
    output IssueValidD, IssueWrD, IssueDstD, IssueLatD,
    output RsD, RtD, UseRsD, UseRtD, BranchD,
    input  StallF, StallD, FlushE, PendingMask, IssueAccepted
  );

  modport slave (
    input  IssueValidD, IssueWrD, IssueDstD, IssueLatD,
    input  RsD, RtD, UseRsD, UseRtD, BranchD,
    output StallF, StallD, FlushE, PendingMask, IssueAccepted
  );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// Per-register countdown scoreboard: stalls decode on RAW (E-stage or branch
// consumer) and WAW ordering hazards; outputs are combinational from the counters.
module mips_hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = 4
) (
  input  logic                    CLK,
  input  logic                    Reset,
  mips_hazard_scoreboard_if.slave hz
);

  logic [LAT_W-1:0] w_cnt [NREGS];
  logic [LAT_W-1:0] w_eff_lat;
  logic [LAT_W-1:0] w_cnt_rs;
  logic [LAT_W-1:0] w_cnt_rt;
  logic [LAT_W-1:0] w_cnt_dst;
  logic             w_raw_a;
  logic             w_raw_b;
  logic             w_waw;
  logic             w_hazard;
  logic             w_accept;
  logic [NREGS-1:0] w_pending;

  assign w_cnt[0] = '0;

  generate
    for (genvar g = 1; g < NREGS; g++) begin : g_cnt
      logic [LAT_W-1:0] r_cnt;
      // A same-cycle issue to this register wins over the decrement.
      always_ff @(posedge CLK) begin
        if (!Reset) begin
          r_cnt <= '0;
        end else if (w_accept && hz.IssueWrD && (hz.IssueDstD == REG_AW'(g))) begin
          r_cnt <= w_eff_lat;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - LAT_W'(1);
        end
      end
      assign w_cnt[g] = r_cnt;
    end
  endgenerate

  always_comb begin
    w_eff_lat = hz.IssueLatD;
    if (hz.IssueLatD == '0) begin
      w_eff_lat = LAT_W'(1);
    end else if (hz.IssueLatD > LAT_W'(MAX_LAT)) begin
      w_eff_lat = LAT_W'(MAX_LAT);
    end
  end

  assign w_cnt_rs  = w_cnt[hz.RsD];
  assign w_cnt_rt  = w_cnt[hz.RtD];
  assign w_cnt_dst = w_cnt[hz.IssueDstD];

  // E-stage consumers can take a value with one cycle left via forwarding;
  // decode-stage branch compares need it already available.
  assign w_raw_a = hz.IssueValidD & hz.UseRsD & (hz.RsD != '0) &
                   (hz.BranchD ? (w_cnt_rs != '0) : (w_cnt_rs > LAT_W'(1)));
  assign w_raw_b = hz.IssueValidD & hz.UseRtD & (hz.RtD != '0) &
                   (hz.BranchD ? (w_cnt_rt != '0) : (w_cnt_rt > LAT_W'(1)));
  assign w_waw   = hz.IssueValidD & hz.IssueWrD & (hz.IssueDstD != '0) &
                   (w_cnt_dst > w_eff_lat);

  assign w_hazard = Reset & (w_raw_a | w_raw_b | w_waw);
  assign w_accept = Reset & hz.IssueValidD & ~w_hazard;

  always_comb begin
    w_pending = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_pending[r] = Reset & (w_cnt[r] != '0);
    end
  end

  assign hz.StallF        = w_hazard;
  assign hz.StallD        = w_hazard;
  assign hz.FlushE        = w_hazard;
  assign hz.IssueAccepted = w_accept;
  assign hz.PendingMask   = w_pending;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Randomized and directed bench; the reference tracks the absolute cycle at
// which each register's value becomes forwardable.
module tb_mips_hazard_scoreboard;
  localparam int NREGS   = 32;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mips_hazard_scoreboard_if #(.NREGS(NREGS), .REG_AW(REG_AW), .LAT_W(LAT_W)) hz_if ();

  mips_hazard_scoreboard #(
    .NREGS(NREGS), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hz    (hz_if.slave)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint now = 0;
  longint ready_at [NREGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, now);
    end
  endtask

  function automatic longint rem(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic int eff(input int lat);
    if (lat == 0) return 1;
    if (lat > MAX_LAT) return MAX_LAT;
    return lat;
  endfunction

  task automatic drive(input int v, input int w, input int d, input int l,
                       input int rs, input int urs, input int rt, input int urt, input int br);
    hz_if.IssueValidD = v[0];
    hz_if.IssueWrD    = w[0];
    hz_if.IssueDstD   = REG_AW'(d);
    hz_if.IssueLatD   = LAT_W'(l);
    hz_if.RsD         = REG_AW'(rs);
    hz_if.UseRsD      = urs[0];
    hz_if.RtD         = REG_AW'(rt);
    hz_if.UseRtD      = urt[0];
    hz_if.BranchD     = br[0];
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_in();
    drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 4) == 0));
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(output bit o_acc, output bit o_stall, output logic [NREGS-1:0] o_mask);
    bit h, a, ra, rb, ww;
    int e;
    logic [NREGS-1:0] m;
    @(negedge CLK);
    e  = eff(int'(hz_if.IssueLatD));
    ra = hz_if.UseRsD && hz_if.RsD != 0 &&
         (hz_if.BranchD ? rem(int'(hz_if.RsD)) > 0 : rem(int'(hz_if.RsD)) > 1);
    rb = hz_if.UseRtD && hz_if.RtD != 0 &&
         (hz_if.BranchD ? rem(int'(hz_if.RtD)) > 0 : rem(int'(hz_if.RtD)) > 1);
    ww = hz_if.IssueWrD && hz_if.IssueDstD != 0 && rem(int'(hz_if.IssueDstD)) > e;
    h  = Reset && hz_if.IssueValidD && (ra || rb || ww);
    a  = Reset && hz_if.IssueValidD && !h;
    m  = '0;
    if (Reset) for (int r = 1; r < NREGS; r++) m[r] = rem(r) > 0;
    chk("stall_f_d_e", {61'd0, hz_if.StallF, hz_if.StallD, hz_if.FlushE}, {61'd0, h, h, h});
    chk("issue_accepted", {63'd0, hz_if.IssueAccepted}, {63'd0, a});
    chk("pending_mask", {32'd0, hz_if.PendingMask}, {32'd0, m});
    o_acc   = hz_if.IssueAccepted;
    o_stall = hz_if.StallF;
    o_mask  = hz_if.PendingMask;
    @(posedge CLK);
    if (!Reset) begin
      for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
    end else if (a && hz_if.IssueWrD && hz_if.IssueDstD != 0) begin
      ready_at[hz_if.IssueDstD] = now + 1 + e;
    end
    now++;
    #1;
  endtask

  task automatic step();
    bit a, s;
    logic [NREGS-1:0] m;
    cyc(a, s, m);
  endtask

  // Holds current inputs until accepted; returns the number of stalled cycles.
  task automatic until_acc(output int n);
    bit a, s;
    logic [NREGS-1:0] m;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(a, s, m);
      if (a) break;
      n++;
    end
  endtask

  // With idle decode, counts cycles register r stays pending.
  task automatic pend_len(input int r, output int n);
    bit a, s;
    logic [NREGS-1:0] m;
    idle_in();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(a, s, m);
      if (!m[r]) break;
      n++;
    end
  endtask

  initial begin
    int n;
    bit a, s;
    logic [NREGS-1:0] m;
    for (int r = 0; r < NREGS; r++) ready_at[r] = 0;

    Reset = 1'b0;
    repeat (2) begin rand_in(); step(); end
    Reset = 1'b1;
    idle_in();
    repeat (10) step();

    // load -> ALU use: one bubble
    drive(1, 1, 5, 2, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 1, 5, 1, 0, 0, 0); until_acc(n);
    chk("load_use_bubbles", 64'(n), 64'd1);
    idle_in(); repeat (10) step();

    // ALU -> branch: one stall; load -> branch: two
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 0, 7, 1, 1); until_acc(n);
    chk("alu_branch_stalls", 64'(n), 64'd1);
    idle_in(); repeat (10) step();
    drive(1, 1, 7, 2, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 0, 7, 1, 1); until_acc(n);
    chk("load_branch_stalls", 64'(n), 64'd2);
    idle_in(); repeat (10) step();

    // WAW: lat 6 then lat 1 to the same register waits while remaining > 1
    drive(1, 1, 9, 6, 0, 0, 0, 0, 0); step();
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0); until_acc(n);
    chk("waw_stalls", 64'(n), 64'd5);
    pend_len(9, n);
    chk("waw_pending_len", 64'(n), 64'd1);
    idle_in(); repeat (10) step();

    // register 0 never tracked; latency clamping
    drive(1, 1, 0, 8, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 1, 0, 1, 0); until_acc(n);
    chk("r0_no_stall", 64'(n), 64'd0);
    idle_in(); cyc(a, s, m);
    chk("r0_mask_clear", 64'(m), 64'd0);
    drive(1, 1, 11, 0, 0, 0, 0, 0, 0); step();
    pend_len(11, n);
    chk("lat0_clamp_len", 64'(n), 64'd1);
    drive(1, 1, 12, 15, 0, 0, 0, 0, 0); step();
    pend_len(12, n);
    chk("lat15_clamp_len", 64'(n), 64'(MAX_LAT));
    idle_in(); repeat (10) step();

    // mid-operation reset drops pending entries
    drive(1, 1, 4, 8, 0, 0, 0, 0, 0); step();
    idle_in(); repeat (3) step();
    Reset = 1'b0; step();
    Reset = 1'b1;
    drive(1, 0, 0, 1, 4, 1, 4, 1, 0); until_acc(n);
    chk("post_reset_no_stall", 64'(n), 64'd0);
    idle_in(); step();

    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) != 0);
      rand_in();
      step();
    end
    Reset = 1'b1;
    idle_in();
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
